// File: rtl/vram_write_ctrl.sv
// ---------------------------------------------------------------------------
// vram_write_ctrl
//
// CPU-side access port for the GPU video memories. The frame synthesizer only
// ever reads VRAM; this block is the other end of that interface and is the
// only thing that writes it. It accepts three kinds of command from the CPU
// bus and turns them into write-port / read-port activity on the two
// memories:
//
//    write : one word written to the selected memory
//    read  : one word read back, presented on bus_q
//    fill  : bus_count consecutive words set to the same value
//
// VRAM32 holds the pattern and palette tables (32-bit words), VRAM8 holds
// the name and attribute tables (8-bit words). Address bit 12 of the bus
// command selects which memory is used; bits 11:0 are the word address.
//
// When WAIT_VBLANK is set, no VRAM access is issued while the display is in
// the tile area (ontile_v=1), so the frame synthesizer's fetches are never
// disturbed. A fill that is interrupted simply pauses and resumes later at
// the next unwritten word.
//
// Parameters
//    WAIT_VBLANK  1 = hold accesses while ontile_v=1, 0 = ignore ontile_v
//
// Ports
//    clk          system clock, everything on the rising edge
//    reset        synchronous, active-high
//    bus_start    command strobe, only looked at while idle
//    bus_op       00 write, 01 read, 10 fill, 11 reserved (no-op)
//    bus_addr     [12] memory select (0 VRAM32, 1 VRAM8), [11:0] word address
//    bus_data     write/fill data (VRAM8 uses [7:0])
//    bus_count    fill length in words
//    bus_busy     high while a command is in progress
//    bus_done     one-cycle completion pulse
//    bus_q        last read result, held until the next read completes
//    ontile_v     1 while the display is inside the tile area
//    vram32_*     VRAM32 address / write data / write enable / read data
//    vram8_*      VRAM8 address / write data / write enable / read data
// ---------------------------------------------------------------------------
module vram_write_ctrl #(
   parameter bit WAIT_VBLANK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_start,
   input  logic [1:0]  bus_op,
   input  logic [12:0] bus_addr,
   input  logic [31:0] bus_data,
   input  logic [11:0] bus_count,
   output logic        bus_busy,
   output logic        bus_done,
   output logic [31:0] bus_q,
   input  logic        ontile_v,
   output logic [11:0] vram32_addr,
   output logic [31:0] vram32_d,
   output logic        vram32_we,
   input  logic [31:0] vram32_q,
   output logic [11:0] vram8_addr,
   output logic [7:0]  vram8_d,
   output logic        vram8_we,
   input  logic [7:0]  vram8_q
);

   localparam logic [1:0] OP_WRITE    = 2'b00;
   localparam logic [1:0] OP_READ     = 2'b01;
   localparam logic [1:0] OP_FILL     = 2'b10;
   localparam logic [1:0] OP_RESERVED = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_VB,
      WRITE,
      FILL,
      RD_ADDR,
      RD_DATA,
      DONE
   } stateT;

   stateT       state;
   stateT       nextState;

   // Command captured at acceptance time; the bus is free to change after.
   logic [1:0]  opReg;
   logic        memSel;
   logic [11:0] addrReg;
   logic [31:0] dataReg;
   logic [11:0] remaining;
   logic [31:0] qReg;

   logic        mustWait;
   logic        noAccess;
   logic        weActive;
   logic        addrActive;

   // Maps an operation code onto the state that actually performs it. The
   // reserved code never reaches here because it is routed straight to DONE.
   function automatic stateT opState(input logic [1:0] op);
      stateT s;
      case (op)
         OP_WRITE: s = WRITE;
         OP_READ:  s = RD_ADDR;
         OP_FILL:  s = FILL;
         default:  s = DONE;
      endcase
      return s;
   endfunction

   // With gating enabled, a high ontile_v at a clock edge means the next
   // cycle must not touch VRAM. With gating disabled it is ignored entirely.
   assign mustWait = WAIT_VBLANK && ontile_v;

   // Commands that never touch VRAM (reserved op, zero-length fill) finish
   // immediately, without waiting for blanking since there is nothing to
   // protect the frame fetches from.
   assign noAccess = (bus_op == OP_RESERVED) ||
                     ((bus_op == OP_FILL) && (bus_count == 12'd0));

   // State register. Reset drops straight back to IDLE from anywhere, which
   // aborts an operation in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A fill re-checks ontile_v on every word so that it
   // can pause mid-block; the word written in the current cycle still lands,
   // and the pause starts with the following word.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (bus_start) begin
               if (noAccess) begin
                  nextState = DONE;
               end else if (mustWait) begin
                  nextState = WAIT_VB;
               end else begin
                  nextState = opState(bus_op);
               end
            end
         end
         WAIT_VB: begin
            if (!mustWait) begin
               nextState = opState(opReg);
            end
         end
         WRITE: begin
            nextState = DONE;
         end
         FILL: begin
            if (remaining == 12'd1) begin
               nextState = DONE;
            end else if (mustWait) begin
               nextState = WAIT_VB;
            end else begin
               nextState = FILL;
            end
         end
         RD_ADDR: begin
            nextState = RD_DATA;
         end
         RD_DATA: begin
            nextState = DONE;
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Command capture and datapath. The fill walks addrReg upward one word per
   // write; the 12-bit register wraps 4095 to 0 on its own, and the memory
   // select bit lives in memSel so a wrap never crosses into the other
   // memory. The read result is taken in RD_DATA because both memories have
   // one cycle of registered read latency after the address in RD_ADDR.
   always_ff @(posedge clk) begin
      if (reset) begin
         opReg     <= OP_WRITE;
         memSel    <= 1'b0;
         addrReg   <= 12'd0;
         dataReg   <= 32'd0;
         remaining <= 12'd0;
         qReg      <= 32'd0;
      end else begin
         if ((state == IDLE) && bus_start) begin
            opReg     <= bus_op;
            memSel    <= bus_addr[12];
            addrReg   <= bus_addr[11:0];
            dataReg   <= bus_data;
            remaining <= bus_count;
         end
         if (state == FILL) begin
            addrReg   <= addrReg + 12'd1;
            remaining <= remaining - 12'd1;
         end
         if (state == RD_DATA) begin
            qReg <= memSel ? {24'd0, vram8_q} : vram32_q;
         end
      end
   end

   // Memory and bus outputs, all decoded from the registered state so none
   // of them depend combinationally on bus inputs. The address is presented
   // only on the selected memory and only while it is being accessed; the
   // other memory sees address 0. Write data is simply the captured word,
   // which is harmless while the write enable is low.
   always_comb begin
      weActive    = 1'b0;
      addrActive  = 1'b0;
      vram32_we   = 1'b0;
      vram8_we    = 1'b0;
      vram32_addr = 12'd0;
      vram8_addr  = 12'd0;
      vram32_d    = dataReg;
      vram8_d     = dataReg[7:0];
      bus_busy    = 1'b0;
      bus_done    = 1'b0;
      bus_q       = qReg;

      weActive   = (state == WRITE) || (state == FILL);
      addrActive = weActive || (state == RD_ADDR);

      if (memSel) begin
         vram8_we = weActive;
         if (addrActive) begin
            vram8_addr = addrReg;
         end
      end else begin
         vram32_we = weActive;
         if (addrActive) begin
            vram32_addr = addrReg;
         end
      end

      bus_busy = (state != IDLE) && (state != DONE);
      bus_done = (state == DONE);
   end

endmodule

// File: tb/tb_vram_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vram_write_ctrl
//
// Bench for vram_write_ctrl. Two behavioural memories with registered reads
// stand in for VRAM32/VRAM8. A command-level reference model predicts, for
// each command, the list of VRAM writes and the completion value of bus_q;
// those predictions go into queues that an independent monitor drains
// whenever the DUT raises a write enable or bus_done.
// ---------------------------------------------------------------------------
module tb_vram_write_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_start;
   logic [1:0]  bus_op;
   logic [12:0] bus_addr;
   logic [31:0] bus_data;
   logic [11:0] bus_count;
   logic        bus_busy;
   logic        bus_done;
   logic [31:0] bus_q;
   logic        ontile_v;
   logic [11:0] vram32_addr;
   logic [31:0] vram32_d;
   logic        vram32_we;
   logic [31:0] vram32_q;
   logic [11:0] vram8_addr;
   logic [7:0]  vram8_d;
   logic        vram8_we;
   logic [7:0]  vram8_q;

   logic        initMem;
   logic        ontilePrev;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        isMem8;
      logic [11:0] addr;
      logic [31:0] data;
   } wrT;

   wrT          writeQ[$];
   logic [31:0] doneQ[$];

   logic [31:0] envMem32 [4096];
   logic [7:0]  envMem8  [4096];
   logic [31:0] refMem32 [4096];
   logic [7:0]  refMem8  [4096];
   logic [31:0] lastQ;

   always #5 clk = ~clk;

   vram_write_ctrl #(.WAIT_VBLANK(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus_start  (bus_start),
      .bus_op     (bus_op),
      .bus_addr   (bus_addr),
      .bus_data   (bus_data),
      .bus_count  (bus_count),
      .bus_busy   (bus_busy),
      .bus_done   (bus_done),
      .bus_q      (bus_q),
      .ontile_v   (ontile_v),
      .vram32_addr(vram32_addr),
      .vram32_d   (vram32_d),
      .vram32_we  (vram32_we),
      .vram32_q   (vram32_q),
      .vram8_addr (vram8_addr),
      .vram8_d    (vram8_d),
      .vram8_we   (vram8_we),
      .vram8_q    (vram8_q)
   );

   // Power-on contents shared by the memory models and the reference model.
   function automatic logic [31:0] initWord32(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'hC0FFEE00;
   endfunction

   function automatic logic [7:0] initWord8(input int i);
      if (i == 'h7F8) return 8'h3C;
      return 8'(i * 7 + 3);
   endfunction

   // VRAM models: synchronous write, one-cycle registered read.
   always @(posedge clk) begin
      if (initMem) begin
         for (int i = 0; i < 4096; i++) begin
            envMem32[i] <= initWord32(i);
            envMem8[i]  <= initWord8(i);
         end
      end else begin
         if (vram32_we) envMem32[vram32_addr] <= vram32_d;
         if (vram8_we)  envMem8[vram8_addr]   <= vram8_d;
      end
      vram32_q <= envMem32[vram32_addr];
      vram8_q  <= envMem8[vram8_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Value of ontile_v at the most recent rising edge.
   initial begin
      ontilePrev = 1'b0;
      forever begin
         @(posedge clk);
         ontilePrev = ontile_v;
      end
   end

   // Monitor: drains the scoreboard whenever the DUT writes or completes.
   initial begin : monitor
      wrT exp;
      forever begin
         @(negedge clk);
         if (vram32_we || vram8_we) begin
            checkOutput("we_exclusive", 32'(vram32_we & vram8_we), 32'd0);
            checkOutput("we_during_tile", 32'(ontilePrev), 32'd0);
            if (writeQ.size() == 0) begin
               checkOutput("unexpected_we", 32'd1, 32'd0);
            end else begin
               exp = writeQ.pop_front();
               checkOutput("we_memory", 32'(vram8_we), 32'(exp.isMem8));
               if (vram8_we) begin
                  checkOutput("we_addr", 32'(vram8_addr), 32'(exp.addr));
                  checkOutput("we_data", {24'd0, vram8_d}, exp.data);
                  checkOutput("inactive_addr", 32'(vram32_addr), 32'd0);
               end else begin
                  checkOutput("we_addr", 32'(vram32_addr), 32'(exp.addr));
                  checkOutput("we_data", vram32_d, exp.data);
                  checkOutput("inactive_addr", 32'(vram8_addr), 32'd0);
               end
            end
         end
         if (bus_done) begin
            checkOutput("busy_in_done", 32'(bus_busy), 32'd0);
            if (doneQ.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               checkOutput("done_bus_q", bus_q, doneQ.pop_front());
            end
         end
      end
   end

   // Issues one command, predicts its effect, and waits for completion.
   // expLat: expected done cycle (start = cycle 0), -1 when not predictable.
   // ontile_v is high for cycles [pulseAt, pulseAt+pulseLen) unless randOntile.
   // pokeAt: cycle in which a stray bus_start is driven (0 = none).
   // resetAt: cycle in which reset is raised for one cycle (0 = none).
   task automatic applyStimulus(input logic [1:0] op, input logic [12:0] addr,
                                input logic [31:0] data, input logic [11:0] count,
                                input int expLat, input int pulseAt, input int pulseLen,
                                input bit randOntile, input int pokeAt, input int resetAt);
      logic        isMem8;
      logic [11:0] a;
      logic [11:0] wa;
      logic [31:0] wd;
      int          nWrites;
      int          cyc;
      bit          finished;

      isMem8 = addr[12];
      a      = addr[11:0];
      wd     = isMem8 ? {24'd0, data[7:0]} : data;
      nWrites = 0;
      if (op == 2'b00) nWrites = 1;
      if (op == 2'b10) nWrites = int'(count);
      if (resetAt > 0 && resetAt < nWrites) nWrites = resetAt;
      for (int i = 0; i < nWrites; i++) begin
         wa = 12'((int'(a) + i) % 4096);
         writeQ.push_back('{isMem8: isMem8, addr: wa, data: wd});
         if (isMem8) refMem8[wa] = wd[7:0];
         else        refMem32[wa] = wd;
      end
      if (op == 2'b01) lastQ = isMem8 ? {24'd0, refMem8[a]} : refMem32[a];
      if (resetAt > 0) lastQ = 32'd0;
      else             doneQ.push_back(lastQ);

      @(posedge clk);
      #2;
      bus_start = 1'b1;
      bus_op    = op;
      bus_addr  = addr;
      bus_data  = data;
      bus_count = count;
      ontile_v  = randOntile ? ($urandom_range(0, 3) == 0) : (pulseAt == 0 && pulseLen > 0);

      cyc = 0;
      finished = 1'b0;
      while (!finished && cyc < 3000) begin
         cyc++;
         @(posedge clk);
         #2;
         bus_start = (cyc == pokeAt);
         if (cyc == pokeAt) begin
            bus_op   = 2'b00;
            bus_addr = 13'($urandom);
            bus_data = $urandom;
         end
         ontile_v = randOntile ? ($urandom_range(0, 3) == 0)
                               : (cyc >= pulseAt && cyc < pulseAt + pulseLen);
         if (resetAt > 0 && cyc == resetAt) reset = 1'b1;
         if (resetAt > 0 && cyc == resetAt + 1) reset = 1'b0;
         @(negedge clk);
         if (resetAt > 0 && cyc == resetAt + 1) begin
            checkOutput("reset_we", {30'd0, vram32_we, vram8_we}, 32'd0);
            checkOutput("reset_busy", 32'(bus_busy), 32'd0);
            checkOutput("reset_done", 32'(bus_done), 32'd0);
            checkOutput("reset_bus_q", bus_q, 32'd0);
            finished = 1'b1;
         end else if (bus_done) begin
            if (expLat >= 0) checkOutput("done_latency", 32'(cyc), 32'(expLat));
            finished = 1'b1;
         end else begin
            checkOutput("busy_active", 32'(bus_busy), 32'd1);
         end
      end
      if (!finished) checkOutput("done_timeout", 32'd0, 32'd1);

      @(posedge clk);
      #2;
      bus_start = 1'b0;
      ontile_v  = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_done", 32'(bus_busy), 32'd0);
   endtask

   initial begin : driver
      logic [1:0]  op;
      logic [11:0] cnt;
      bit          rnd;
      int          lat;

      reset     = 1'b1;
      initMem   = 1'b1;
      bus_start = 1'b0;
      bus_op    = 2'b00;
      bus_addr  = 13'd0;
      bus_data  = 32'd0;
      bus_count = 12'd0;
      ontile_v  = 1'b0;
      lastQ     = 32'd0;
      for (int i = 0; i < 4096; i++) begin
         refMem32[i] = initWord32(i);
         refMem8[i]  = initWord8(i);
      end

      @(posedge clk);
      #2;
      initMem = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy", 32'(bus_busy), 32'd0);
      checkOutput("rst_done", 32'(bus_done), 32'd0);
      checkOutput("rst_bus_q", bus_q, 32'd0);
      checkOutput("rst_we", {30'd0, vram32_we, vram8_we}, 32'd0);
      checkOutput("rst_vram32_addr", 32'(vram32_addr), 32'd0);
      checkOutput("rst_vram8_addr", 32'(vram8_addr), 32'd0);
      checkOutput("rst_vram32_d", vram32_d, 32'd0);
      checkOutput("rst_vram8_d", 32'(vram8_d), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      $display("[TB] directed commands");
      applyStimulus(2'b00, 13'h0405, 32'hDEADBEEF, 12'd0, 2, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b01, 13'h17F8, 32'd0, 12'd0, 3, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b10, 13'h1FFE, 32'hFFFFFFA5, 12'd4, 5, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b01, 13'h1FFF, 32'd0, 12'd0, 3, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b01, 13'h1000, 32'd0, 12'd0, 3, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b01, 13'h0405, 32'd0, 12'd0, 3, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b00, 13'h0FFF, 32'h12345678, 12'd0, 2, 0, 0, 1'b0, 0, 0);

      $display("[TB] blank gating");
      applyStimulus(2'b00, 13'h0010, 32'hCAFEF00D, 12'd0, 5, 0, 3, 1'b0, 0, 0);
      applyStimulus(2'b01, 13'h0010, 32'd0, 12'd0, 7, 0, 4, 1'b0, 0, 0);
      applyStimulus(2'b10, 13'h0123, 32'h5555AAAA, 12'd10, 16, 4, 5, 1'b0, 0, 0);
      applyStimulus(2'b10, 13'h1FFB, 32'h0000007E, 12'd8, 12, 2, 3, 1'b0, 0, 0);

      $display("[TB] edge commands");
      applyStimulus(2'b10, 13'h0200, 32'h11111111, 12'd0, 1, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b11, 13'h0300, 32'h22222222, 12'd7, 1, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b10, 13'h0400, 32'h33333333, 12'd6, 7, 0, 0, 1'b0, 3, 0);
      applyStimulus(2'b00, 13'h1400, 32'h44444444, 12'd0, 2, 0, 0, 1'b0, 2, 0);
      applyStimulus(2'b01, 13'h0400, 32'd0, 12'd0, 3, 0, 0, 1'b0, 1, 0);

      $display("[TB] reset during fill");
      applyStimulus(2'b10, 13'h0800, 32'h99999999, 12'd100, -1, 0, 0, 1'b0, 0, 20);
      applyStimulus(2'b01, 13'h0813, 32'd0, 12'd0, 3, 0, 0, 1'b0, 0, 0);
      applyStimulus(2'b01, 13'h0814, 32'd0, 12'd0, 3, 0, 0, 1'b0, 0, 0);

      $display("[TB] random commands");
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: op = 2'b00;
            4, 5, 6:    op = 2'b01;
            7, 8:       op = 2'b10;
            default:    op = 2'b11;
         endcase
         cnt = 12'($urandom_range(0, 12));
         rnd = 1'($urandom_range(0, 1));
         case (op)
            2'b00:   lat = 2;
            2'b01:   lat = 3;
            2'b10:   lat = (cnt == 12'd0) ? 1 : int'(cnt) + 1;
            default: lat = 1;
         endcase
         if (rnd) lat = -1;
         applyStimulus(op, 13'($urandom), $urandom, cnt, lat, 0, 0, rnd, 0, 0);
      end

      repeat (3) @(negedge clk);
      checkOutput("writes_drained", 32'(writeQ.size()), 32'd0);
      checkOutput("dones_drained", 32'(doneQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/vram_write_ctrl.md
Name: vram_write_ctrl

Overview:
- CPU-side writer/reader port for the GPU video memories, the opposite end of the VRAM interface from the frame synthesizer, which only reads VRAM.
- Accepts single-word write, single-word read and block-fill commands from the CPU bus and drives the write ports of VRAM32 (pattern/palette tables) and VRAM8 (name/attribute tables).
- Optionally holds VRAM accesses until the display is outside the tile area, so frame fetches are never disturbed.

Parameters:
- WAIT_VBLANK, 1, when 1 every VRAM access (we or read address) is issued only while ontile_v=0; when 0 ontile_v is ignored.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- bus_start  input  1  command strobe; sampled only in IDLE.
- bus_op  input  2  00 write, 01 read, 10 fill, 11 reserved.
- bus_addr  input  13  [12]=0 VRAM32, [12]=1 VRAM8; [11:0] word address.
- bus_data  input  32  write/fill data; VRAM8 uses [7:0].
- bus_count  input  12  fill length in words.
- bus_busy  output  1  high from the cycle after an accepted start until done.
- bus_done  output  1  one-cycle completion pulse.
- bus_q  output  32  read result; VRAM8 reads are zero-extended.
- ontile_v  input  1  from the frame synthesizer; 1 = display is in the tile area.
- vram32_addr  output  12  VRAM32 address.
- vram32_d  output  32  VRAM32 write data.
- vram32_we  output  1  VRAM32 write enable.
- vram32_q  input  32  VRAM32 read data; 1-cycle registered latency.
- vram8_addr  output  12  VRAM8 address.
- vram8_d  output  8  VRAM8 write data.
- vram8_we  output  1  VRAM8 write enable.
- vram8_q  input  8  VRAM8 read data; 1-cycle registered latency.

Behaviour:
- Reset:
  - state IDLE; all outputs 0, including bus_q.
  - Reset mid-operation aborts immediately; no further we; no done pulse.
- States: IDLE, WAIT_VB, WRITE, FILL, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - bus_start=1 captures op, addr, data and count.
  - Next state is WAIT_VB if WAIT_VBLANK=1 and ontile_v=1; otherwise the op state.
  - bus_busy=1 from the next cycle.
- Op mapping: op 11 goes straight to DONE (no VRAM access). Fill with count=0 also goes straight to DONE.
- WAIT_VB: leaves for the op state in the cycle after ontile_v is sampled 0.
- WRITE: exactly one cycle of we on the selected memory with the captured addr/data, then DONE.
- FILL:
  - we=1 on consecutive cycles; address increments by 1 each write; remaining count decrements.
  - Address wraps 4095→0 within the same memory; addr[12] never changes.
  - After the count-th write, go to DONE.
  - If WAIT_VBLANK=1 and ontile_v is sampled 1 during a fill, we drops the next cycle and the fill pauses in WAIT_VB. It resumes at the next unwritten address with no skip and no duplicate.
- RD_ADDR: drives the read address for one cycle (we=0).
- RD_DATA: samples vram32_q or {24'b0, vram8_q} into bus_q, then DONE.
- DONE:
  - bus_done=1 and bus_busy=0 for one cycle, then IDLE.
  - A bus_start in the DONE cycle is ignored.
- bus_start while busy is ignored; no queuing.
- Read latency with no wait: start at cycle 0, address at cycle 1, bus_q valid with done at cycle 3.
- Write latency with no wait: we at cycle 1, done at cycle 2. Fill of N words with no wait: we on cycles 1..N, done at cycle N+1.
- bus_q holds its value until the next read completes; writes and fills do not alter it.
- Address outputs:
  - Inactive memory's address = 0.
  - we is never high on both memories at once.
  - vram*_d is don't-care when we=0 (drive the captured data).

Test Plan:
- Write: WAIT_VBLANK=1, ontile_v=0; write addr 0x0405, data 0xDEADBEEF → vram32_we=1 at cycle 1 with addr 0x405, d 0xDEADBEEF; done at cycle 2; vram8_we stays 0.
- VRAM8 read: preload VRAM8[0x7F8]=0x3C; read addr 0x17F8 → bus_q=0x0000003C with done at cycle 3.
- Fill wrap: fill addr 0x1FFE, count 4, data 0xA5 → VRAM8 writes at 0xFFE, 0xFFF, 0x000, 0x001, each 0xA5; done at cycle 5.
- Blank gating:
  - ontile_v=1 at start → no we until ontile_v=0.
  - Fill of 10 with ontile_v pulsed high for 5 cycles mid-fill → exactly 10 unique consecutive addresses written, then done.
- Edge commands: fill count 0 and op 11 → done at cycle 1, zero we. bus_start during busy → ignored, single done.
- Reset: reset during a fill of 100 after 20 writes → we=0 the next cycle, busy=0, no done, bus_q=0.
